// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, stall and halt controller for the five-stage core
//
// Drives the PC and FD/DE/EM/MW latch enables and bubble flushes.
// Freezes on data-memory waits. Inserts load-use bubbles.
// Squashes wrong-path instructions on jumps and taken branches.
// Holds a sticky halt once a halt instruction reaches MEM.
//
// Ports:
//   CLK, RST                         core clock, synchronous active-high reset
//   ihit, dhit                       fetch / data access complete this cycle
//   dmemREN_me, dmemWEN_me           MEM-stage load / store request
//   memRead_ex, regDst_ex            EX-stage load and its destination
//   rs_de, rt_de, useRs_de, useRt_de DE-stage sources and whether they are read
//   jump_de, branchTaken_me, halt_me redirects and halt
//   pc_en, fd_en, de_en, em_en, mw_en  load enables (combinational)
//   fd_flush, de_flush, em_flush       bubble insert on the next edge
//   halt                             registered, 1 exactly while HALTED
//   dstall_cnt, lu_cnt, flush_cnt    performance counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// performance counters. When it is undefined, the counter ports read 0
// and no counter flops exist.

module hazard_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmemREN_me,
    input  logic        dmemWEN_me,
    input  logic        memRead_ex,
    input  logic [4:0]  regDst_ex,
    input  logic [4:0]  rs_de,
    input  logic [4:0]  rt_de,
    input  logic        useRs_de,
    input  logic        useRt_de,
    input  logic        jump_de,
    input  logic        branchTaken_me,
    input  logic        halt_me,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        halt,
    output logic [31:0] dstall_cnt,
    output logic [31:0] lu_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    logic dReq;
    logic loadUse;
    logic active;
    logic freezeFire;
    logic branchFire;
    logic luFire;
    logic haltGo;

    assign dReq    = (dmemREN_me | dmemWEN_me) & ~dhit;
    assign loadUse = memRead_ex & (regDst_ex != 5'd0) &
                     ((useRs_de & (rs_de == regDst_ex)) |
                      (useRt_de & (rt_de == regDst_ex)));

    // Rules 2..4 only fire when neither reset nor halt already owns the pipeline.
    assign active     = ~RST & (state != HALTED);
    assign freezeFire = active & dReq;
    assign branchFire = active & ~dReq & branchTaken_me;
    assign luFire     = active & ~dReq & ~branchTaken_me & loadUse;
    // A halt in MEM may retire only once its memory access is done.
    assign haltGo     = active & ~dReq & halt_me;

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        if (RST || state == HALTED) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = RST;
            de_flush = RST;
            em_flush = RST;
        end else if (dReq) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
            mw_en = 1'b0;
        end else if (branchTaken_me) begin
            // Branch wins over load-use; the dependent instruction is squashed anyway.
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (loadUse) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (jump_de) begin
            fd_flush = 1'b1;
            pc_en    = ihit;
        end else if (!ihit) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (haltGo) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (dReq) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (haltGo) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (dhit) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            dstall_cnt <= 32'd0;
            lu_cnt     <= 32'd0;
            flush_cnt  <= 32'd0;
        end else begin
            if (freezeFire && dstall_cnt != 32'hFFFF_FFFF) dstall_cnt <= dstall_cnt + 32'd1;
            if (luFire     && lu_cnt     != 32'hFFFF_FFFF) lu_cnt     <= lu_cnt + 32'd1;
            if (branchFire && flush_cnt  != 32'hFFFF_FFFF) flush_cnt  <= flush_cnt + 32'd1;
        end
    end
`else
    assign dstall_cnt = 32'd0;
    assign lu_cnt     = 32'd0;
    assign flush_cnt  = 32'd0;

    logic unusedFire;
    assign unusedFire = freezeFire ^ luFire ^ branchFire;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model

module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dmemREN_me, dmemWEN_me, memRead_ex;
    logic [4:0]  regDst_ex, rs_de, rt_de;
    logic        useRs_de, useRt_de, jump_de, branchTaken_me, halt_me;
    logic        pc_en, fd_en, de_en, em_en, mw_en;
    logic        fd_flush, de_flush, em_flush, halt;
    logic [31:0] dstall_cnt, lu_cnt, flush_cnt;

    int checks = 0;
    int passes = 0;

    bit          mHalted;
    logic [31:0] mDst, mLu, mFl;

    always #5 CLK = ~CLK;

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_me(dmemREN_me), .dmemWEN_me(dmemWEN_me),
        .memRead_ex(memRead_ex), .regDst_ex(regDst_ex),
        .rs_de(rs_de), .rt_de(rt_de), .useRs_de(useRs_de), .useRt_de(useRt_de),
        .jump_de(jump_de), .branchTaken_me(branchTaken_me), .halt_me(halt_me),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .halt(halt), .dstall_cnt(dstall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Which rule owns this cycle: 0 reset, 1 halted, 2 freeze, 3 branch, 4 load-use, 5 jump, 6 no fetch, 7 none.
    function automatic int whichRule();
        bit memWait, hazard;
        memWait = (dmemREN_me || dmemWEN_me) && !dhit;
        hazard  = memRead_ex && regDst_ex != 0 &&
                  ((useRs_de && rs_de == regDst_ex) || (useRt_de && rt_de == regDst_ex));
        if (RST)            return 0;
        if (mHalted)        return 1;
        if (memWait)        return 2;
        if (branchTaken_me) return 3;
        if (hazard)         return 4;
        if (jump_de)        return 5;
        if (!ihit)          return 6;
        return 7;
    endfunction

    // Expected {pc,fd,de,em,mw enables, fd,de,em flushes}.
    function automatic logic [7:0] expCtl();
        case (whichRule())
            0:       return 8'b00000_111;
            1, 2:    return 8'b00000_000;
            3:       return 8'b11111_111;
            4:       return 8'b00111_010;
            5:       return {ihit, 4'b1111, 3'b100};
            6:       return 8'b01111_100;
            default: return 8'b11111_000;
        endcase
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic evalCycle();
        #3;
        chk("ctl", {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush}, {24'd0, expCtl()});
        chk("halt", {31'd0, halt}, {31'd0, mHalted});
`ifdef HAZARD_PERF_CNT_EN
        chk("dstall_cnt", dstall_cnt, mDst);
        chk("lu_cnt", lu_cnt, mLu);
        chk("flush_cnt", flush_cnt, mFl);
`else
        chk("cnt_tied", dstall_cnt | lu_cnt | flush_cnt, 32'd0);
`endif
    endtask

    task automatic advance();
        int r;
        bit memWait;
        r = whichRule();
        memWait = (dmemREN_me || dmemWEN_me) && !dhit;
        @(posedge CLK);
        if (r == 0) begin
            mHalted = 0; mDst = 0; mLu = 0; mFl = 0;
        end else if (r != 1) begin
            if (r == 2) mDst = satInc(mDst);
            if (r == 3) mFl  = satInc(mFl);
            if (r == 4) mLu  = satInc(mLu);
            if (halt_me && !memWait) mHalted = 1;
        end
        #1;
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 0; dmemREN_me = 0; dmemWEN_me = 0;
        memRead_ex = 0; regDst_ex = 0; rs_de = 0; rt_de = 0;
        useRs_de = 0; useRt_de = 0; jump_de = 0; branchTaken_me = 0; halt_me = 0;
    endtask

    task automatic setLoadUse(input logic [4:0] r);
        memRead_ex = 1; regDst_ex = r; useRs_de = 1; rs_de = r;
    endtask

    initial begin
        idle();
        RST = 1;
        mHalted = 0; mDst = 0; mLu = 0; mFl = 0;
        @(posedge CLK); #1;
        evalCycle();
        chk("rst_flush", {29'd0, fd_flush, de_flush, em_flush}, 32'd7);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        advance();

        // Load-use on $5 stalls; against $0 it must not.
        idle(); setLoadUse(5'd5); evalCycle();
        chk("lu_enables", {28'd0, pc_en, fd_en, de_flush, em_en}, 32'b0011);
        advance();
        idle(); setLoadUse(5'd0); evalCycle();
        chk("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
        advance();

        // Three-cycle dcache miss, then hit.
        for (int i = 0; i < 3; i++) begin
            idle(); dmemREN_me = 1; evalCycle();
            chk("miss_freeze", {27'd0, pc_en, fd_en, de_en, em_en, mw_en}, 32'd0);
            advance();
        end
        idle(); dmemREN_me = 1; dhit = 1; evalCycle(); advance();
`ifdef HAZARD_PERF_CNT_EN
        chk("dstall_three", dstall_cnt, 32'd3);
`endif

        // Taken branch with concurrent load-use: no bubble, all three flushed.
        idle(); setLoadUse(5'd7); branchTaken_me = 1; evalCycle();
        chk("br_lu", {27'd0, pc_en, de_en, fd_flush, de_flush, em_flush}, 32'b11111);
        advance();

        idle(); ihit = 0; evalCycle();
        chk("nofetch", {26'd0, pc_en, fd_flush, de_en, em_en, mw_en, de_flush}, 32'b011110);
        advance();
        idle(); jump_de = 1; evalCycle();
        chk("jump", {30'd0, pc_en, fd_flush}, 32'b11);
        advance();

        // Halt behind a pending store.
        for (int i = 0; i < 2; i++) begin
            idle(); halt_me = 1; dmemWEN_me = 1; evalCycle(); advance();
            chk("halt_wait", {31'd0, halt}, 32'd0);
        end
        idle(); halt_me = 1; dmemWEN_me = 1; dhit = 1; evalCycle(); advance();
        idle(); evalCycle();
        chk("halted", {26'd0, halt, pc_en, fd_en, de_en, em_en, mw_en}, 32'b100000);
        advance();
        idle(); RST = 1; evalCycle(); advance();
        idle(); evalCycle();
        chk("halt_cleared", {31'd0, halt}, 32'd0);
        advance();

        // Reset in the middle of a miss.
        for (int i = 0; i < 2; i++) begin
            idle(); dmemREN_me = 1; evalCycle(); advance();
        end
        idle(); RST = 1; dmemREN_me = 1; evalCycle(); advance();
        idle(); evalCycle();
        chk("rst_dwait", {dstall_cnt | lu_cnt | flush_cnt}, 32'd0);
        chk("rst_dwait_pc", {31'd0, pc_en}, 32'd1);
        advance();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            RST            = ($urandom % 40) == 0;
            ihit           = ($urandom % 4) != 0;
            dhit           = ($urandom % 3) != 0;
            dmemREN_me     = ($urandom % 4) == 0;
            dmemWEN_me     = ($urandom % 6) == 0;
            memRead_ex     = ($urandom % 3) == 0;
            regDst_ex      = 5'($urandom % 4);
            rs_de          = 5'($urandom % 4);
            rt_de          = 5'($urandom % 4);
            useRs_de       = 1'($urandom % 2);
            useRt_de       = 1'($urandom % 2);
            jump_de        = ($urandom % 8) == 0;
            branchTaken_me = ($urandom % 8) == 0;
            halt_me        = ($urandom % 30) == 0;
            evalCycle();
            advance();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the forwarding unit and drives the enable and flush inputs of the four pipeline latches (FD, DE, EM, MW) and the PC. It freezes the pipeline on data-memory waits, inserts load-use bubbles that forwarding cannot cover, and squashes wrong-path instructions on jumps and taken branches. It also holds a sticky halt state once a halt instruction reaches MEM.

## Interface
Parameters:
- none (types come from cpu_types_pkg: word_t 32, regbits_t 5)

Ports:
- Reset is synchronous and active-high.
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmemREN_me, dmemWEN_me  in  1 each  MEM-stage load/store request.
- memRead_ex  in  1  EX-stage instruction is a load.
- regDst_ex  in  5  EX-stage destination register.
- rs_de, rt_de  in  5 each  DE-stage source registers.
- useRs_de, useRt_de  in  1 each  DE-stage instruction reads rs/rt.
- jump_de  in  1  DE-stage j/jal/jr redirect.
- branchTaken_me  in  1  MEM-stage branch resolved taken.
- halt_me  in  1  MEM-stage instruction is halt.
- pc_en, fd_en, de_en, em_en, mw_en  out  1 each  latch/PC load enables.
- fd_flush, de_flush, em_flush  out  1 each  load bubble into the latch on the next edge.
- halt  out  1  registered sticky halt.
- dstall_cnt, lu_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
FSM states: RUN, DWAIT, HALTED. Reset state is RUN.

Define dReq = (dmemREN_me | dmemWEN_me) & ~dhit.

Define loadUse = memRead_ex & (regDst_ex != 0) & ((useRs_de & rs_de == regDst_ex) | (useRt_de & rt_de == regDst_ex)).

Outputs are evaluated in priority order; the first matching rule wins. Defaults are all enables 1 and all flushes 0.
1. RST or state HALTED: all enables 0; all flushes 0 (RST additionally forces fd/de/em_flush 1).
2. dReq (RUN or DWAIT): all enables 0, all flushes 0 (full freeze).
3. branchTaken_me: pc_en 1; fd_flush, de_flush, em_flush 1.
4. loadUse: pc_en 0, fd_en 0, de_flush 1; em and mw advance.
5. jump_de: fd_flush 1; pc_en = ihit.
6. ~ihit: pc_en 0, fd_flush 1; other stages advance.

halt_me is honoured only when dReq is 0. It lets MEM→WB complete this cycle, then the FSM enters HALTED.

Transitions:
- RUN→DWAIT on dReq.
- DWAIT→RUN on dhit.
- RUN/DWAIT→HALTED on halt_me & ~dReq.
- HALTED→RUN only on RST.

halt is registered: it is 1 exactly when state is HALTED.

## Timing
- Enables and flushes are combinational from state and inputs; zero-cycle latency. The latches sample them on the same CLK edge.
- halt asserts one edge after the cycle with halt_me & ~dReq.
- Reset values: state RUN, halt 0, all counters 0.
- Reset mid-DWAIT returns to RUN. The pending access is abandoned and the upstream memory controller must also reset.
- Simultaneous branchTaken_me and loadUse: the branch wins and no bubble is inserted (the load-use instruction is flushed).
- Simultaneous dReq and branchTaken_me: freeze; the branch is applied in the cycle dhit arrives.
- Simultaneous halt_me and branchTaken_me (no dReq): enter HALTED; the flushes still apply on that edge.
- loadUse against register $0 never stalls.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - dstall_cnt increments every cycle rule 2 fires.
  - lu_cnt increments every cycle rule 4 fires.
  - flush_cnt increments every cycle rule 3 fires.
  - All three saturate at 32'hFFFFFFFF, clear on RST, and hold in HALTED.
- Undefined: the ports still exist and are tied to 0; no counter flops are synthesized.

## Test plan
- Load-use: memRead_ex=1, regDst_ex=5, useRs_de=1, rs_de=5 → pc_en=0, fd_en=0, de_flush=1, em_en=1. Repeat with regDst_ex=0 → no stall.
- Dcache miss: dmemREN_me=1, dhit=0 for 3 cycles then 1 → all enables 0 for 3 cycles while state=DWAIT, RUN after dhit. With the macro, dstall_cnt=3.
- Taken branch with concurrent load-use → fd/de/em_flush=1, pc_en=1, de_en=1 (no bubble); flush_cnt increments by 1.
- ihit=0 with no other hazard → pc_en=0, fd_flush=1, de/em/mw_en=1. jump_de=1 with ihit=1 → fd_flush=1, pc_en=1.
- halt_me=1 while dmemWEN_me=1, dhit=0 → halt stays 0 until dhit; halt=1 one edge later and all enables 0 thereafter. RST=1 → halt=0, state RUN.
- RST asserted during DWAIT with counters nonzero → next cycle state RUN and all counters 0.
